// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter that shares one function-select register among N requesters.
// Each grant issues exactly one register op and returns the post-op value with an ack pulse.
module reg_access_arbiter #(
   parameter int             N         = 3,
   parameter int             W         = 32,
   parameter logic [N-1:0]   PRIV_MASK = 3'b001
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [N-1:0]     req,
   input  logic [3*N-1:0]   reqFunSel,
   input  logic [W*N-1:0]   reqData,
   output logic [N-1:0]     grant,
   output logic [N-1:0]     ack,
   output logic             err,
   output logic [W-1:0]     rdata,
   output logic             regEnable,
   output logic [2:0]       regFunSel,
   output logic [W-1:0]     regI,
   input  logic [W-1:0]     regO
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_ACK     = 2'd3;

   localparam logic [2:0] FS_CLEAR  = 3'b011;

   logic [1:0]    r_state;
   logic [PW-1:0] r_ptr;
   logic [PW-1:0] r_win;
   logic [N-1:0]  r_grant;
   logic [N-1:0]  r_ack;
   logic          r_err;
   logic          r_err_pend;
   logic [W-1:0]  r_rdata;
   logic          r_reg_en;
   logic [2:0]    r_reg_fs;
   logic [W-1:0]  r_reg_i;

   logic          w_found;
   logic [PW-1:0] w_win_idx;
   logic [N-1:0]  w_win_oh;
   logic [2:0]    w_fs;
   logic [W-1:0]  w_d;
   logic          w_refuse;

   // Round-robin scan: first set req bit at or above the pointer, wrapping to 0.
   always_comb begin : scan
      logic [PW:0] cand;
      // NOTE: every combinational output gets a default first so no latch is inferred.
      w_found   = 1'b0;
      w_win_idx = '0;
      cand      = '0;
      for (int off = 0; off < N; off++) begin
         cand = {1'b0, r_ptr} + (PW+1)'(off);
         if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
         if (!w_found && req[cand[PW-1:0]]) begin
            w_found   = 1'b1;
            w_win_idx = cand[PW-1:0];
         end
      end
   end

   always_comb begin
      w_win_oh = '0;
      w_fs     = '0;
      w_d      = '0;
      w_refuse = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (w_win_idx == PW'(k)) begin
            w_win_oh[k] = 1'b1;
            w_fs        = reqFunSel[3*k +: 3];
            w_d         = reqData[W*k +: W];
            w_refuse    = (reqFunSel[3*k +: 3] == FS_CLEAR) && !PRIV_MASK[k];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_ptr      <= '0;
         r_win      <= '0;
         r_grant    <= '0;
         r_ack      <= '0;
         r_err      <= 1'b0;
         r_err_pend <= 1'b0;
         r_rdata    <= '0;
         r_reg_en   <= 1'b0;
         r_reg_fs   <= '0;
         r_reg_i    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant    <= w_win_oh;
                  r_win      <= w_win_idx;
                  r_err_pend <= w_refuse;
                  if (!w_refuse) begin
                     r_reg_en <= 1'b1;
                     r_reg_fs <= w_fs;
                     r_reg_i  <= w_d;
                  end
                  // Refused ops still pass through ISSUE (enable low) to keep the ack latency uniform.
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_reg_en <= 1'b0;
               r_state  <= S_CAPTURE;
            end
            S_CAPTURE: begin
               r_rdata <= regO;
               r_ack   <= r_grant;
               r_err   <= r_err_pend;
               r_grant <= '0;
               r_ptr   <= (r_win == PW'(N-1)) ? '0 : r_win + 1'b1;
               r_state <= S_ACK;
            end
            default: begin
               r_ack      <= '0;
               r_err      <= 1'b0;
               r_err_pend <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   assign grant     = r_grant;
   assign ack       = r_ack;
   assign err       = r_err;
   assign rdata     = r_rdata;
   assign regEnable = r_reg_en;
   assign regFunSel = r_reg_fs;
   assign regI      = r_reg_i;

endmodule
